// File: rtl/iterative_alu.sv
// Multi-cycle ALU: single-cycle add/sub/compare/logic, bit-serial shifts and a
// shift-add unsigned multiply, launched through a start/busy/done handshake.
module iterative_alu #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SHAMT_WIDTH = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_high,
  output logic             carry,
  output logic             low,
  output logic             flag,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned CW = SHAMT_WIDTH + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_CMP = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {IDLE, SHIFT, MULT} state_e;

  state_e             state, state_n;
  logic [3:0]         op_q, op_n;
  logic [WIDTH-1:0]   work, work_n;
  logic [WIDTH-1:0]   mcand, mcand_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [2*WIDTH-1:0] prod, prod_n;

  logic               done_n, carry_n, low_n, flag_n, zero_n, negative_n;
  logic [WIDTH-1:0]   result_n, result_high_n;

  logic [WIDTH:0]     sum, diff, mul_sum;
  logic [WIDTH-1:0]   sh_val;
  logic               sh_out, is_shift;
  logic [2*WIDTH-1:0] mul_next;

  assign busy = (state != IDLE);

  always_comb begin
    state_n       = state;
    op_n          = op_q;
    work_n        = work;
    mcand_n       = mcand;
    cnt_n         = cnt;
    prod_n        = prod;
    done_n        = 1'b0;
    result_n      = result;
    result_high_n = result_high;
    carry_n       = carry;
    low_n         = low;
    flag_n        = flag;
    zero_n        = zero;
    negative_n    = negative;

    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    is_shift = (op == OP_SHL) || (op == OP_SHR) || (op == OP_SRA);

    // One step of the serial shifter on the latched value.
    sh_val = {1'b0, work[WIDTH-1:1]};
    sh_out = work[0];
    if (op_q == OP_SHL) begin
      sh_val = {work[WIDTH-2:0], 1'b0};
      sh_out = work[WIDTH-1];
    end else if (op_q == OP_SRA) begin
      sh_val = {work[WIDTH-1], work[WIDTH-1:1]};
    end

    // Shift-add: multiplier occupies the low half and is consumed LSB first.
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    mul_next = {mul_sum, prod[WIDTH-1:1]};

    unique case (state)
      IDLE: begin
        if (start) begin
          op_n = op;
          if (is_shift && (a[SHAMT_WIDTH-1:0] != '0)) begin
            state_n = SHIFT;
            work_n  = b;
            cnt_n   = {1'b0, a[SHAMT_WIDTH-1:0]};
          end else if (op == OP_MUL) begin
            state_n = MULT;
            prod_n  = {{WIDTH{1'b0}}, b};
            mcand_n = a;
            cnt_n   = CW'(WIDTH);
          end else begin
            done_n        = 1'b1;
            result_n      = '0;
            result_high_n = '0;
            carry_n       = 1'b0;
            low_n         = 1'b0;
            flag_n        = 1'b0;
            zero_n        = 1'b0;
            negative_n    = 1'b0;
            case (op)
              OP_ADD: begin
                result_n = sum[WIDTH-1:0];
                carry_n  = sum[WIDTH];
                flag_n   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                zero_n   = (sum[WIDTH-1:0] == '0);
              end
              OP_SUB: begin
                result_n = diff[WIDTH-1:0];
                carry_n  = diff[WIDTH];
                flag_n   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                zero_n   = (diff[WIDTH-1:0] == '0);
              end
              OP_CMP: begin
                result_n   = diff[WIDTH-1:0];
                zero_n     = (a == b);
                low_n      = (a < b);
                negative_n = ($signed(a) < $signed(b));
              end
              OP_AND: begin
                result_n = a & b;
                zero_n   = ((a & b) == '0);
              end
              OP_OR: begin
                result_n = a | b;
                zero_n   = ((a | b) == '0);
              end
              OP_XOR: begin
                result_n = a ^ b;
                zero_n   = ((a ^ b) == '0);
              end
              OP_SHL, OP_SHR, OP_SRA: begin
                result_n = b;
                zero_n   = (b == '0);
              end
              default: ;
            endcase
          end
        end
      end

      SHIFT: begin
        work_n = sh_val;
        cnt_n  = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n       = IDLE;
          done_n        = 1'b1;
          result_n      = sh_val;
          result_high_n = '0;
          carry_n       = sh_out;
          low_n         = 1'b0;
          flag_n        = 1'b0;
          zero_n        = (sh_val == '0);
          negative_n    = 1'b0;
        end
      end

      MULT: begin
        prod_n = mul_next;
        cnt_n  = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n       = IDLE;
          done_n        = 1'b1;
          result_n      = mul_next[WIDTH-1:0];
          result_high_n = mul_next[2*WIDTH-1:WIDTH];
          carry_n       = 1'b0;
          low_n         = 1'b0;
          flag_n        = (mul_next[2*WIDTH-1:WIDTH] != '0);
          zero_n        = (mul_next == '0);
          negative_n    = 1'b0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= '0;
      work        <= '0;
      mcand       <= '0;
      cnt         <= '0;
      prod        <= '0;
      done        <= 1'b0;
      result      <= '0;
      result_high <= '0;
      carry       <= 1'b0;
      low         <= 1'b0;
      flag        <= 1'b0;
      zero        <= 1'b0;
      negative    <= 1'b0;
    end else begin
      state       <= state_n;
      op_q        <= op_n;
      work        <= work_n;
      mcand       <= mcand_n;
      cnt         <= cnt_n;
      prod        <= prod_n;
      done        <= done_n;
      result      <= result_n;
      result_high <= result_high_n;
      carry       <= carry_n;
      low         <= low_n;
      flag        <= flag_n;
      zero        <= zero_n;
      negative    <= negative_n;
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Directed, table-driven bench for iterative_alu at WIDTH=16, plus hand-written
// sequences for dropped starts, mid-operation reset and back-to-back issue.
module tb_iterative_alu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op    = '0;
  logic [15:0] a     = '0;
  logic [15:0] b     = '0;
  logic        busy, done, carry, low, flag, zero, negative;
  logic [15:0] result, result_high;

  int errors = 0;
  int checks = 0;

  iterative_alu #(.WIDTH(16), .SHAMT_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .result_high(result_high),
    .carry(carry), .low(low), .flag(flag), .zero(zero), .negative(negative)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [15:0] hi;
    logic        c, l, f, z, n;
    int          lat;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock);
    #1;
    // Scramble inputs so later changes would corrupt an unlatched operation.
    start = 1'b0; op = 4'd3; a = 16'hDEAD; b = 16'hBEEF;
  endtask

  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic chk_outputs(input string tag, input vec_t v);
    chk({tag, ".result"},      {16'h0, result},      {16'h0, v.res});
    chk({tag, ".result_high"}, {16'h0, result_high}, {16'h0, v.hi});
    chk({tag, ".flags"}, {27'h0, carry, low, flag, zero, negative},
        {27'h0, v.c, v.l, v.f, v.z, v.n});
  endtask

  initial begin
    int lat, bc, dcount;
    vec_t v;

    //         op     a         b         res       hi        c  l  f  z  n  lat
    vecs[0]  = '{4'd0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 0, 0, 1, 0, 0, 1};
    vecs[1]  = '{4'd1, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 1, 0, 0, 0, 0, 1};
    vecs[2]  = '{4'd2, 16'hFFFF, 16'h0001, 16'hFFFE, 16'h0000, 0, 0, 0, 0, 1, 1};
    vecs[3]  = '{4'd2, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 1};
    vecs[4]  = '{4'd6, 16'h0005, 16'h8001, 16'h0020, 16'h0000, 0, 0, 0, 0, 0, 6};
    vecs[5]  = '{4'd8, 16'h0004, 16'h8000, 16'hF800, 16'h0000, 0, 0, 0, 0, 0, 5};
    vecs[6]  = '{4'd7, 16'h0000, 16'h00F0, 16'h00F0, 16'h0000, 0, 0, 0, 0, 0, 1};
    vecs[7]  = '{4'd9, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 0, 1, 0, 0, 17};
    vecs[8]  = '{4'd9, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 17};
    vecs[9]  = '{4'd3, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 0, 0, 0, 0, 0, 1};
    vecs[10] = '{4'd4, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 1};
    vecs[11] = '{4'd5, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, 0, 0, 0, 0, 0, 1};
    vecs[12] = '{4'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1, 0, 0, 1, 0, 1};
    vecs[13] = '{4'd1, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 0, 0, 1, 0, 0, 1};
    vecs[14] = '{4'd7, 16'h0001, 16'h0003, 16'h0001, 16'h0000, 1, 0, 0, 0, 0, 2};
    vecs[15] = '{4'd6, 16'h00FF, 16'h0001, 16'h8000, 16'h0000, 0, 0, 0, 0, 0, 16};
    vecs[16] = '{4'd8, 16'h0003, 16'h000C, 16'h0001, 16'h0000, 1, 0, 0, 0, 0, 4};
    vecs[17] = '{4'd9, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 0, 0, 0, 0, 0, 17};
    vecs[18] = '{4'd9, 16'h1000, 16'h0100, 16'h0000, 16'h0010, 0, 0, 1, 0, 0, 17};
    vecs[19] = '{4'd12, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1};
    vecs[20] = '{4'd7, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 1};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset.busy", {31'h0, busy}, 32'h0);
    chk("reset.done", {31'h0, done}, 32'h0);
    v = '{4'd0, 16'h0, 16'h0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0};
    chk_outputs("reset", v);

    for (int i = 0; i < 21; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, bc);
      chk({tag, ".latency"},    lat, vecs[i].lat);
      chk({tag, ".busy_cycles"}, bc, vecs[i].lat - 1);
      chk({tag, ".busy_at_done"}, {31'h0, busy}, 32'h0);
      chk_outputs(tag, vecs[i]);
      @(negedge clock);
      chk({tag, ".done_single"}, {31'h0, done}, 32'h0);
    end

    // Start while busy is dropped; MUL result must be unaffected.
    issue(4'd9, 16'h0003, 16'h0005);
    repeat (4) @(negedge clock);
    chk("drop.busy", {31'h0, busy}, 32'h1);
    start = 1'b1; op = 4'd0; a = 16'h0001; b = 16'h0001;
    @(negedge clock);
    start = 1'b0;
    wait_done(lat, bc);
    chk("drop.latency", lat, 17 - 5);
    v = '{4'd9, 16'h0, 16'h0, 16'h000F, 16'h0000, 0, 0, 0, 0, 0, 0};
    chk_outputs("drop", v);
    dcount = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (done) dcount++;
    end
    chk("drop.no_extra_done", dcount, 0);
    chk("drop.hold_result", {16'h0, result}, 32'h000F);

    // Mid-operation reset aborts with outputs cleared and no done.
    issue(4'd9, 16'hFFFF, 16'hFFFF);
    repeat (7) @(negedge clock);
    chk("abort.busy_before", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    chk("abort.busy", {31'h0, busy}, 32'h0);
    chk("abort.done", {31'h0, done}, 32'h0);
    v = '{4'd0, 16'h0, 16'h0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0};
    chk_outputs("abort", v);
    @(negedge clock);
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (done || busy) dcount++;
    end
    chk("abort.quiet", dcount, 0);

    // ADD issued in the done cycle of a shift.
    issue(4'd6, 16'h0002, 16'h0001);
    wait_done(lat, bc);
    chk("b2b.shift_latency", lat, 3);
    chk("b2b.shift_result", {16'h0, result}, 32'h0004);
    start = 1'b1; op = 4'd0; a = 16'h0010; b = 16'h0020;
    @(posedge clock);
    #1;
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
    @(negedge clock);
    chk("b2b.add_done", {31'h0, done}, 32'h1);
    v = '{4'd0, 16'h0, 16'h0, 16'h0030, 16'h0000, 0, 0, 0, 0, 0, 0};
    chk_outputs("b2b.add", v);
    @(negedge clock);
    chk("b2b.done_clear", {31'h0, done}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iterative_alu.md
# iterative_alu

Parametrised, multi-cycle arithmetic/logic unit for the CPU datapath. It keeps the single-cycle add/sub/compare/logic behaviour with its five status flags. It adds variable-amount shifts (one bit per cycle) and an unsigned shift-add multiply with a double-width product. Operations are launched with a start/busy/done handshake, so the controller FSM stalls on `busy` instead of assuming fixed latency. Results and flags are registered and feed the result register and status register inputs.

## Interface
- `WIDTH`, 16, operand/result width; must be ≥4 and a power of two.
- `SHAMT_WIDTH`, log2(WIDTH) (4), width of the shift-amount field taken from `a`.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  launch request; sampled only when `busy`=0.
- `op`  in  4  operation code, captured with `start`.
- `a`  in  WIDTH  operand A (shift amount in `a[SHAMT_WIDTH-1:0]` for shifts).
- `b`  in  WIDTH  operand B (value being shifted for shifts).
- `busy`  out  1  operation in progress; `start` is ignored while high.
- `done`  out  1  one-cycle pulse: `result`/flags just updated.
- `result`  out  WIDTH  registered result (low half of product for MUL).
- `result_high`  out  WIDTH  high half of product (MUL only; 0 for other ops).
- `carry`, `low`, `flag`, `zero`, `negative`  out  1 each  registered flags.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 CMP, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR (logical), 8 SRA, 9 MUL (unsigned), 10–15 undefined.
- ADD: d=a+b. `carry`=bit WIDTH of the sum. `flag`=signed overflow (a,b same sign, d differs). `zero`=(d==0).
- SUB: d=a−b. `carry`=borrow (a<b unsigned). `flag`=signed overflow (a,b differ in sign, d sign≠a sign). `zero`=(d==0).
- CMP: `result`=a−b. `zero`=(a==b). `low`=(a<b unsigned). `negative`=(a<b signed). `carry` and `flag` are 0.
- AND/OR/XOR: bitwise result; `zero`=(d==0); all other flags 0.
- SHL/SHR/SRA: shift `b` by n=`a[SHAMT_WIDTH-1:0]`, one bit per cycle. SRA replicates the sign bit. `carry`=last bit shifted out (0 if n=0). `zero`=(d==0).
- MUL: 2·WIDTH-bit product of a·b, computed one multiplier bit per cycle (shift-add). `result`=low half, `result_high`=high half. `zero`=(product==0). `flag`=(high half ≠0).
- Undefined op: `result`=0, all flags 0, single-cycle latency.
- Every flag not listed for an op is written 0. `result_high` is written 0 for every non-MUL op.
- Outputs change only on a completing edge and hold until the next completion.
- FSM states:
  - IDLE: on `start`, single-cycle ops (and shifts with n=0) compute, register and pulse `done` and stay in IDLE. Shifts with n≥1 go to SHIFT. MUL goes to MULT.
  - SHIFT: decrement the counter each cycle; at count 0 register outputs, pulse `done`, return to IDLE.
  - MULT: WIDTH iterations, then same completion.
- Operands and op are latched at the start edge; input changes afterwards have no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `result_high`=0, all flags 0, state IDLE.
- Asserting `reset` mid-operation aborts it immediately: no `done` pulse, outputs cleared.
- Latency, counted from the edge sampling `start` to the cycle `done` is high:
  - single-cycle ops: 1
  - shift by n≥1: n+1
  - MUL: WIDTH+1 (17 at WIDTH=16)
- `busy` is high from the cycle after a multi-cycle start through the last compute cycle. `busy` is low in the cycle where `done` is high.
- `start` is accepted in any cycle with `busy`=0, including a `done` cycle, allowing back-to-back issue. `start` while `busy`=1 is dropped; no queueing.
- `done` is never high for two consecutive cycles from one operation.

## Test plan
- ADD a=0x7FFF b=0x0001 → 1 cycle later `done`=1, `result`=0x8000, `flag`=1, `carry`=0, `zero`=0; SUB a=0x0000 b=0x0001 → 0xFFFF, `carry`=1, `flag`=0.
- CMP a=0xFFFF b=0x0001 → `low`=0, `negative`=1, `zero`=0, `result`=0xFFFE; CMP a=b=0x1234 → `zero`=1, `low`=0, `negative`=0.
- SHL a=5 b=0x8001 → `busy` for 5 cycles, `done` at cycle 6, `result`=0x0020, `carry`=0; SRA a=4 b=0x8000 → 0xF800; SHR a=0 b=0x00F0 → 1 cycle, 0x00F0, `carry`=0.
- MUL a=0xFFFF b=0xFFFF → `done` at cycle 17, `result`=0x0001, `result_high`=0xFFFE, `flag`=1; MUL a=0 b=0x1234 → `zero`=1, `flag`=0.
- Start MUL; pulse `start` with ADD at cycle 5 → ignored, MUL result unchanged; assert `reset` at cycle 8 of a second MUL → `busy`=0 and all outputs 0 immediately, no `done`.
- Back-to-back: ADD issued in the `done` cycle of a shift → accepted, `done` again 1 cycle later with the ADD result.
